rs_seg_adder: RTL and testbench
===============================

RS_SEG_ADDER -- requirements
Module: rs_seg_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 64: total operand and result width in bits.
REQ-002 SHALL have parameter SEG, default 16: bits added per cycle; SEG <= `MAX_CARRY_CHAIN`.
REQ-003 SHALL have port C, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port R, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1: operand set offered.
REQ-006 SHALL have port in_ready, output, 1: block can accept an operand set.
REQ-007 SHALL have port a, input, WIDTH: operand A, unsigned two's-complement bit vector.
REQ-008 SHALL have port b, input, WIDTH: operand B.
REQ-009 SHALL have port sub, input, 1: 0 computes a+b; 1 computes a-b.
REQ-010 SHALL have port out_valid, output, 1: result available.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-012 SHALL have port sum, output, WIDTH: result.
REQ-013 SHALL have port co, output, 1: carry out of bit WIDTH-1.

Function
REQ-014 SHALL compute NSEG = WIDTH/SEG segments; WIDTH not a multiple of SEG, or SEG > `MAX_CARRY_CHAIN`, SHALL be an elaboration error.
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 IDLE: in_ready=1; on in_valid&in_ready, register a, b^{WIDTH{sub}}, set carry register to sub, set index to 0, go RUN.
REQ-017 RUN: in_ready=0; each cycle, add segment[index] of A, segment[index] of inverted B and carry register; write result into sum[index*SEG +: SEG]; update carry register; increment index.
REQ-018 RUN with index = NSEG-1: after the update, go DONE; co = final carry.
REQ-019 DONE: out_valid=1; sum and co held stable until out_ready=1, then go IDLE on the same edge.
REQ-020 Latency: out_valid SHALL assert exactly NSEG cycles after the accepting edge.
REQ-021 in_ready and out_valid SHALL never be 1 together; there is no accept in the cycle that the result is consumed.
REQ-022 Carry SHALL propagate across segments only through the carry register; there is no combinational path between segments.
REQ-023 Subtraction: co=1 iff a >= b unsigned (no-borrow convention).
REQ-024 Inputs a, b and sub SHALL be sampled only on the accepting edge; later changes have no effect.

Reset
REQ-025 R=0 SHALL immediately force state to IDLE, index to 0, carry register to 0, sum to 0, co to 0, and out_valid to 0. in_ready reads 1 once R=1.
REQ-026 Reset during RUN or DONE SHALL discard the operation; no out_valid is issued for it.

Configuration
REQ-027 With macro RS_SEG_ADDER_OVF_EN defined, the block SHALL add output ovf (1 bit), registered in DONE as signed overflow = carry into MSB XOR carry out of MSB; ovf is reset to 0.
REQ-028 Without RS_SEG_ADDER_OVF_EN, there SHALL be no ovf port and no related logic.

Structure
REQ-029 Package rs_arith_pkg SHALL hold the FSM state enum (IDLE/RUN/DONE) and a helper function for the index width, $clog2(NSEG) with a minimum of 1.
REQ-030 Sub-module rs_seg_slice SHALL provide a combinational SEG-bit add with ports a, b, ci, s, co, ci_msb (carry into the top bit). It maps to the ADDER_CARRY chain via techmap, and a single instance is reused each cycle.

Verification (WIDTH=64, SEG=16)
REQ-031 a=64'hFFFF_FFFF_FFFF_FFFF, b=1, sub=0 -> sum=0, co=1, out_valid exactly 4 cycles after accept.
REQ-032 a=5, b=7, sub=1 -> sum=64'hFFFF_FFFF_FFFF_FFFE, co=0; a=7, b=5, sub=1 -> sum=2, co=1.
REQ-033 out_ready=0 for 10 cycles in DONE -> out_valid, sum and co stable; in_ready=0 throughout; in_valid is ignored.
REQ-034 R pulsed low at RUN cycle 2 -> out_valid=0, sum=0, co=0; the next operation (a=1, b=2) -> sum=3, co=0.
REQ-035 With RS_SEG_ADDER_OVF_EN: a=64'h7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> ovf=1, sum=64'h8000_0000_0000_0000; a=1, b=1 -> ovf=0.

Source files
------------

// File: rtl/rs_arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rs_arith_pkg
//  Description : Shared types and helpers for the segmented ripple adder.
//                Holds the sequencer state encoding and the index-width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package rs_arith_pkg;

    // Sequencer states of the segmented adder
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of the segment index; a single-segment build still needs one bit
    function automatic int idx_width(input int nseg);
        return (nseg > 1) ? $clog2(nseg) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rs_seg_slice.sv
`default_nettype none
// ============================================================================
//  Module      : rs_seg_slice
//  Description : Combinational SEG-bit adder slice with carry in/out and the
//                carry into its top bit (for signed-overflow detection).
//                Written as a plain '+' so it lands on the dedicated
//                ADDER_CARRY chain; the top level reuses one instance for
//                every segment.
//  Revision    : 1.0  initial release
// ============================================================================
module rs_seg_slice #(
    parameter int SEG = 16
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co,
    output logic           ci_msb
);

    // One carry chain covering the whole slice
    assign {co, s} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};

    // Sum bit = a ^ b ^ carry-in, so the carry into the top bit is recoverable
    assign ci_msb = a[SEG-1] ^ b[SEG-1] ^ s[SEG-1];

endmodule
`default_nettype wire

// File: rtl/rs_seg_adder.sv
`default_nettype none
// ============================================================================
//  Module      : rs_seg_adder
//  Description : Multi-cycle WIDTH-bit adder/subtractor that processes SEG bits
//                per clock through a single reused slice. Carry between
//                segments travels only through carry_q, so the critical path
//                is one SEG-bit chain. Valid/ready on both sides.
//                Optional macro RS_SEG_ADDER_OVF_EN adds a signed-overflow
//                output 'ovf'.
//  Revision    : 1.0  initial release
// ============================================================================
`ifndef MAX_CARRY_CHAIN
`define MAX_CARRY_CHAIN 64
`endif

module rs_seg_adder
    import rs_arith_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SEG   = 16
) (
    input  logic             C,
    input  logic             R,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co
`ifdef RS_SEG_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int              NSEG     = WIDTH / SEG;
    localparam int              IDXW     = idx_width(NSEG);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSEG - 1);

    generate
        if ((SEG < 1) || ((WIDTH % SEG) != 0) || (SEG > `MAX_CARRY_CHAIN)) begin : g_cfg_error
            $error("rs_seg_adder: WIDTH must be a multiple of SEG and SEG must not exceed MAX_CARRY_CHAIN");
        end
    endgenerate

    state_e            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              co_q, co_d;
    logic [WIDTH-1:0]  a_q, b_q;

    logic              w_accept;
    logic              w_last;
    logic [31:0]       w_lsb;
    logic [SEG-1:0]    w_seg_a, w_seg_b, w_seg_s;
    logic              w_seg_co, w_seg_ci_msb;

    assign w_accept = (state_q == IDLE) && in_valid;
    assign w_last   = (state_q == RUN) && (idx_q == LAST_IDX);
    assign w_lsb    = 32'(idx_q) * SEG;
    assign w_seg_a  = a_q[w_lsb +: SEG];
    assign w_seg_b  = b_q[w_lsb +: SEG];

    rs_seg_slice #(
        .SEG (SEG)
    ) u_slice (
        .a      (w_seg_a),
        .b      (w_seg_b),
        .ci     (carry_q),
        .s      (w_seg_s),
        .co     (w_seg_co),
        .ci_msb (w_seg_ci_msb)
    );

    // Operand capture on the accepting edge only; B is pre-inverted for subtract
    always_ff @(posedge C) begin
        if (w_accept) begin
            a_q <= a;
            b_q <= b ^ {WIDTH{sub}};
        end
    end

    // Sequencer state, segment index, inter-segment carry and result registers
    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            co_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
        end
    end

    // Next-state and handshake outputs; ready and valid come from disjoint states
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        sum_d     = sum_q;
        co_d      = co_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    carry_d = sub;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[w_lsb +: SEG] = w_seg_s;
                carry_d             = w_seg_co;
                idx_d               = idx_q + IDXW'(1);
                if (idx_q == LAST_IDX) begin
                    co_d    = w_seg_co;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sum = sum_q;
    assign co  = co_q;

`ifdef RS_SEG_ADDER_OVF_EN
    logic ovf_q;

    // Signed overflow of the top segment, captured as the result completes
    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            ovf_q <= 1'b0;
        end else if (w_last) begin
            ovf_q <= w_seg_ci_msb ^ w_seg_co;
        end
    end

    assign ovf = ovf_q;
`else
    logic w_unused_ci_msb;
    assign w_unused_ci_msb = w_seg_ci_msb;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rs_seg_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rs_seg_adder
//  Description : Self-checking bench for rs_seg_adder (WIDTH=64, SEG=16).
//                Vector table plus random operands against a 65-bit reference
//                sum, scoreboard queue, hold/back-pressure and mid-run reset
//                sequences. Checks ovf when RS_SEG_ADDER_OVF_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rs_seg_adder;

    localparam int WIDTH = 64;
    localparam int SEG   = 16;
    localparam int NSEG  = WIDTH / SEG;

    logic             C = 1'b0;
    logic             R = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             co;
`ifdef RS_SEG_ADDER_OVF_EN
    logic             ovf;
`endif

    always #5 C = ~C;

    rs_seg_adder #(
        .WIDTH (WIDTH),
        .SEG   (SEG)
    ) dut (
        .C         (C),
        .R         (R),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .co        (co)
`ifdef RS_SEG_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    typedef struct {
        logic [63:0] sum;
        logic        co;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        sub;
        logic [63:0] sum;
        logic        co;
        logic        ovf;
    } vec_t;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];
    vec_t vecs[13];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: full-width add of A and (B xor sub) with sub as carry-in
    function automatic exp_t model(input logic [63:0] x, input logic [63:0] y, input logic s);
        exp_t        m;
        logic [63:0] yy;
        logic [64:0] t;
        yy    = y ^ {64{s}};
        t     = {1'b0, x} + {1'b0, yy} + {64'd0, s};
        m.sum = t[63:0];
        m.co  = t[64];
        m.ovf = (x[63] == yy[63]) && (t[63] != x[63]);
        return m;
    endfunction

    // Scoreboard consumer: compare whenever a result is handed over
    always @(negedge C) begin
        exp_t e;
        if (R) begin
            check("ready_valid_exclusive", {127'd0, in_ready & out_valid}, 128'd0);
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_result", 128'd1, 128'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("sum", {64'd0, sum}, {64'd0, e.sum});
                    check("co", {127'd0, co}, {127'd0, e.co});
`ifdef RS_SEG_ADDER_OVF_EN
                    check("ovf", {127'd0, ovf}, {127'd0, e.ovf});
`endif
                end
            end
        end
    end

    // One complete transaction; optional back-pressure with in_valid noise
    task automatic run_op(input logic [63:0] va, input logic [63:0] vb, input logic vsub,
                          input exp_t e, input int hold, input bit noise);
        int          guard;
        int          lat;
        bit          busy_bad;
        logic [63:0] s0;
        logic        c0;
        @(negedge C);
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        sub      = vsub;
        guard    = 0;
        while (!in_ready && guard < 20) begin
            @(negedge C);
            guard++;
        end
        if (!in_ready) begin
            check("accept_timeout", 128'd0, 128'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge C);
        sb_q.push_back(e);
        #1;
        in_valid = 1'b0;
        a        = {$urandom, $urandom};
        b        = {$urandom, $urandom};
        sub      = ~vsub;
        lat      = 0;
        busy_bad = 1'b0;
        while (!out_valid && lat < 20) begin
            if (in_ready) busy_bad = 1'b1;
            @(posedge C);
            #1;
            lat++;
        end
        check("latency", 128'(lat), 128'(NSEG));
        check("in_ready_busy", {127'd0, busy_bad}, 128'd0);
        if (hold > 0) begin
            s0       = sum;
            c0       = co;
            in_valid = noise;
            for (int i = 0; i < hold; i++) begin
                @(posedge C);
                #1;
                a = {$urandom, $urandom};
                b = {$urandom, $urandom};
                check("hold_stable", {61'd0, out_valid, in_ready, co, sum},
                      {61'd0, 1'b1, 1'b0, c0, s0});
            end
        end
        out_ready = 1'b1;
        @(posedge C);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("idle_after_consume", {126'd0, out_valid, in_ready}, 128'd1);
    endtask

    initial begin
        vecs[0]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h0, 1'b1, 1'b0};
        vecs[1]  = '{64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vecs[2]  = '{64'd7, 64'd5, 1'b1, 64'd2, 1'b1, 1'b0};
        vecs[3]  = '{64'd1, 64'd2, 1'b0, 64'd3, 1'b0, 1'b0};
        vecs[4]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[5]  = '{64'd1, 64'd1, 1'b0, 64'd2, 1'b0, 1'b0};
        vecs[6]  = '{64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
        vecs[7]  = '{64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h0001_0000_0000_0000, 1'b0, 1'b0};
        vecs[8]  = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        vecs[9]  = '{64'd0, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0};
        vecs[10] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
                     64'h2222_2222_2222_2211, 1'b0, 1'b0};
        vecs[11] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                     64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0};
        vecs[12] = '{64'd5, 64'd5, 1'b1, 64'd0, 1'b1, 1'b0};

        // Power-on reset: outputs forced low while R is asserted
        #1 R = 1'b0;
        #1;
        check("reset_out_valid", {127'd0, out_valid}, 128'd0);
        check("reset_sum", {64'd0, sum}, 128'd0);
        check("reset_co", {127'd0, co}, 128'd0);
        repeat (3) @(negedge C);
        R = 1'b1;
        @(negedge C);
        check("ready_after_reset", {127'd0, in_ready}, 128'd1);

        // Table vectors
        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub,
                   '{vecs[i].sum, vecs[i].co, vecs[i].ovf}, 0, 1'b0);
        end

        // Random operands against the reference sum
        for (int i = 0; i < 8; i++) begin
            logic [63:0] ra;
            logic [63:0] rb;
            logic        rs;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rs = 1'($urandom_range(0, 1));
            run_op(ra, rb, rs, model(ra, rb, rs), 0, 1'b0);
        end

        // Back-pressure: 10 cycles of out_ready=0 with in_valid asserted
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, '{64'h0, 1'b1, 1'b0}, 10, 1'b1);
        @(posedge C);
        #1;
        check("no_accept_after_consume", {127'd0, in_ready}, 128'd1);

        // Reset pulse in the middle of a run discards the operation
        @(negedge C);
        in_valid = 1'b1;
        a        = 64'h1234_5678_9ABC_DEF0;
        b        = 64'h0FED_CBA9_8765_4321;
        sub      = 1'b0;
        @(posedge C);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge C);
        #2;
        R = 1'b0;
        #1;
        check("midrun_reset_out_valid", {127'd0, out_valid}, 128'd0);
        check("midrun_reset_sum", {64'd0, sum}, 128'd0);
        check("midrun_reset_co", {127'd0, co}, 128'd0);
        sb_q.delete();
        @(negedge C);
        R = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge C);
            #1;
            check("no_valid_after_reset", {126'd0, out_valid, in_ready}, 128'd1);
        end
        run_op(64'd1, 64'd2, 1'b0, '{64'd3, 1'b0, 1'b0}, 0, 1'b0);

        repeat (2) @(negedge C);
        check("scoreboard_empty", 128'(sb_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
